reorder_buffer: RTL and testbench

//  In-order retirement queue between Dispatcher/CDB and the RegisterFile commit port.

---
 rtl/reorder_buffer.sv | 144 ++++++++++++++
 tb/tb_reorder_buffer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer
//   In-order retirement queue sitting between the dispatcher / CDB and the
//   register-file commit port. One entry is allocated per dispatched
//   instruction. Results broadcast on the CDB are captured into their entries.
//   The head entry retires once it is complete, at most one per cycle.
//   A mispredicted branch at the head flushes the whole buffer and redirects
//   fetch.
//
// Ports
//   Sys_clk / Sys_rst / Sys_rdy : clock, synchronous active-high reset,
//                                 global enable (all state frozen when low)
//   DPRoB_*  / RoBDP_*          : allocation request, full / next index,
//                                 operand tag lookup (Qj/Qk -> Vj/Vk)
//   CDBRoB_*                    : result broadcast (index, value, branch outcome)
//   RoBRF_*                     : commit port (head index, rd, value, pre_judge)
//   RoBIF_*                     : fetch redirect on mispredict
module reorder_buffer #(
    parameter int RoB_WIDTH    = 8,
    parameter int EX_REG_WIDTH = 6,
    parameter int EX_RoB_WIDTH = 9
) (
    input  logic                    Sys_clk,
    input  logic                    Sys_rst,
    input  logic                    Sys_rdy,
    input  logic                    DPRoB_en,
    input  logic [1:0]              DPRoB_type,
    input  logic [EX_REG_WIDTH-1:0] DPRoB_rd,
    input  logic                    DPRoB_pred_jump,
    input  logic [31:0]             DPRoB_alt_pc,
    input  logic [EX_RoB_WIDTH-1:0] DPRoB_Qj,
    input  logic [EX_RoB_WIDTH-1:0] DPRoB_Qk,
    output logic                    RoBDP_full,
    output logic [RoB_WIDTH-1:0]    RoBDP_index,
    output logic                    RoBDP_Vj_rdy,
    output logic                    RoBDP_Vk_rdy,
    output logic [31:0]             RoBDP_Vj,
    output logic [31:0]             RoBDP_Vk,
    input  logic                    CDBRoB_en,
    input  logic [RoB_WIDTH-1:0]    CDBRoB_index,
    input  logic [31:0]             CDBRoB_value,
    input  logic                    CDBRoB_jump,
    output logic                    RoBRF_en,
    output logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
    output logic [EX_REG_WIDTH-1:0] RoBRF_rd,
    output logic [31:0]             RoBRF_value,
    output logic                    RoBRF_pre_judge,
    output logic                    RoBIF_flush,
    output logic [31:0]             RoBIF_pc
);
    localparam int RoB_SIZE = 1 << RoB_WIDTH;
    localparam logic [EX_REG_WIDTH-1:0] NON_REG = {1'b1, {(EX_REG_WIDTH-1){1'b0}}};
    localparam logic [EX_RoB_WIDTH-1:0] NON_DEP = {1'b1, {(EX_RoB_WIDTH-1){1'b0}}};
    localparam logic [1:0] T_BRANCH = 2'b01;

    // per-entry state
    logic [RoB_SIZE-1:0]     busy, ready;
    logic [1:0]              typ_q    [RoB_SIZE];
    logic [EX_REG_WIDTH-1:0] rd_q     [RoB_SIZE];
    logic [31:0]             value_q  [RoB_SIZE];
    logic [31:0]             alt_pc_q [RoB_SIZE];
    logic                    pred_q   [RoB_SIZE];
    logic                    jump_q   [RoB_SIZE];

    logic [RoB_WIDTH-1:0] head, tail;
    logic [RoB_WIDTH:0]   count;

    logic mispredict, alloc, commit, cdb_wr;

    // Commit looks only at registered head state; a CDB write to the head
    // becomes visible one cycle later.
    assign RoBRF_en        = Sys_rdy & busy[head] & ready[head];
    assign mispredict      = RoBRF_en & (typ_q[head] == T_BRANCH) & (jump_q[head] != pred_q[head]);
    assign RoBRF_pre_judge = ~mispredict;
    assign RoBIF_flush     = mispredict;
    assign RoBIF_pc        = alt_pc_q[head];
    assign RoBRF_RoB_index = head;
    assign RoBRF_rd        = rd_q[head];
    assign RoBRF_value     = value_q[head];

    assign RoBDP_full  = (count == (RoB_WIDTH+1)'(RoB_SIZE));
    assign RoBDP_index = tail;

    // A flush discards everything else happening on the same edge.
    assign alloc  = Sys_rdy & DPRoB_en & ~RoBDP_full & ~mispredict;
    assign commit = RoBRF_en & ~mispredict;
    assign cdb_wr = Sys_rdy & CDBRoB_en & busy[CDBRoB_index] & ~mispredict;

    // Operand lookup: completed entry first, then same-cycle CDB forward.
    function automatic logic [32:0] lookup(input logic [EX_RoB_WIDTH-1:0] q);
        logic [RoB_WIDTH-1:0] idx;
        idx = q[RoB_WIDTH-1:0];
        if (q == NON_DEP)                           return '0;
        else if (ready[idx])                        return {1'b1, value_q[idx]};
        else if (CDBRoB_en && CDBRoB_index == idx)  return {1'b1, CDBRoB_value};
        else                                        return '0;
    endfunction

    assign {RoBDP_Vj_rdy, RoBDP_Vj} = lookup(DPRoB_Qj);
    assign {RoBDP_Vk_rdy, RoBDP_Vk} = lookup(DPRoB_Qk);

    // control state: pointers, count, busy/ready
    always_ff @(posedge Sys_clk) begin
        if (Sys_rst || mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            ready <= '0;
        end else if (Sys_rdy) begin
            if (cdb_wr) ready[CDBRoB_index] <= 1'b1;
            // alloc needs !full and commit needs !empty, so tail and head
            // never collide on the same edge
            if (alloc) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= 1'b0;
                tail        <= tail + RoB_WIDTH'(1);
            end
            if (commit) begin
                busy[head] <= 1'b0;
                head       <= head + RoB_WIDTH'(1);
            end
            case ({alloc, commit})
                2'b10:   count <= count + (RoB_WIDTH+1)'(1);
                2'b01:   count <= count - (RoB_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // payload storage, no reset needed (qualified by busy/ready)
    always_ff @(posedge Sys_clk) begin
        if (cdb_wr) begin
            value_q[CDBRoB_index] <= CDBRoB_value;
            jump_q[CDBRoB_index]  <= CDBRoB_jump;
        end
        if (alloc) begin
            // reserved type 11 behaves as a no-rd entry
            typ_q[tail]    <= (DPRoB_type == 2'b11) ? 2'b10 : DPRoB_type;
            rd_q[tail]     <= (DPRoB_type == 2'b00) ? DPRoB_rd : NON_REG;
            pred_q[tail]   <= DPRoB_pred_jump;
            alt_pc_q[tail] <= DPRoB_alt_pc;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
    localparam logic [5:0] NON_REG = 6'b100000;
    localparam logic [8:0] NON_DEP = 9'b100000000;

    logic        Sys_clk = 1'b0, Sys_rst = 1'b1, Sys_rdy = 1'b1;
    logic        DPRoB_en, DPRoB_pred_jump;
    logic [1:0]  DPRoB_type;
    logic [5:0]  DPRoB_rd;
    logic [31:0] DPRoB_alt_pc;
    logic [8:0]  DPRoB_Qj, DPRoB_Qk;
    logic        RoBDP_full, RoBDP_Vj_rdy, RoBDP_Vk_rdy;
    logic [7:0]  RoBDP_index;
    logic [31:0] RoBDP_Vj, RoBDP_Vk;
    logic        CDBRoB_en, CDBRoB_jump;
    logic [7:0]  CDBRoB_index;
    logic [31:0] CDBRoB_value;
    logic        RoBRF_en, RoBRF_pre_judge, RoBIF_flush;
    logic [7:0]  RoBRF_RoB_index;
    logic [5:0]  RoBRF_rd;
    logic [31:0] RoBRF_value, RoBIF_pc;

    int n_tests = 0, n_fail = 0;

    always #5 Sys_clk = ~Sys_clk;

    reorder_buffer dut (
        .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
        .DPRoB_en(DPRoB_en), .DPRoB_type(DPRoB_type), .DPRoB_rd(DPRoB_rd),
        .DPRoB_pred_jump(DPRoB_pred_jump), .DPRoB_alt_pc(DPRoB_alt_pc),
        .DPRoB_Qj(DPRoB_Qj), .DPRoB_Qk(DPRoB_Qk),
        .RoBDP_full(RoBDP_full), .RoBDP_index(RoBDP_index),
        .RoBDP_Vj_rdy(RoBDP_Vj_rdy), .RoBDP_Vk_rdy(RoBDP_Vk_rdy),
        .RoBDP_Vj(RoBDP_Vj), .RoBDP_Vk(RoBDP_Vk),
        .CDBRoB_en(CDBRoB_en), .CDBRoB_index(CDBRoB_index),
        .CDBRoB_value(CDBRoB_value), .CDBRoB_jump(CDBRoB_jump),
        .RoBRF_en(RoBRF_en), .RoBRF_RoB_index(RoBRF_RoB_index), .RoBRF_rd(RoBRF_rd),
        .RoBRF_value(RoBRF_value), .RoBRF_pre_judge(RoBRF_pre_judge),
        .RoBIF_flush(RoBIF_flush), .RoBIF_pc(RoBIF_pc)
    );

    // ---------------- reference model: ordered queue of live entries ----------------
    typedef struct {
        int          idx;
        logic [1:0]  typ;
        logic [5:0]  rd;
        logic        pred;
        logic [31:0] alt;
        bit          rdy;
        logic [31:0] val;
        logic        jmp;
    } ent_t;

    ent_t        mq[$];
    int          mtail = 0;
    bit          mrdy[256];
    logic [31:0] mval[256];

    function automatic bit m_commit();
        return Sys_rdy && mq.size() > 0 && mq[0].rdy;
    endfunction

    function automatic bit m_mis();
        return m_commit() && mq[0].typ == 2'b01 && mq[0].jmp != mq[0].pred;
    endfunction

    function automatic logic [32:0] m_look(input logic [8:0] q);
        if (q == NON_DEP) return '0;
        if (mrdy[q[7:0]]) return {1'b1, mval[q[7:0]]};
        if (CDBRoB_en && CDBRoB_index == q[7:0]) return {1'b1, CDBRoB_value};
        return '0;
    endfunction

    task automatic m_clear();
        mq.delete();
        mtail = 0;
        foreach (mrdy[i]) mrdy[i] = 1'b0;
    endtask

    // apply one clock edge to the model using the currently driven inputs
    task automatic model_edge();
        bit com, full;
        ent_t e;
        if (Sys_rst) begin m_clear(); return; end
        if (!Sys_rdy) return;
        if (m_mis()) begin m_clear(); return; end
        com  = m_commit();
        full = (mq.size() == 256);
        if (CDBRoB_en)
            foreach (mq[i])
                if (mq[i].idx == int'(CDBRoB_index)) begin
                    mq[i].rdy = 1'b1; mq[i].val = CDBRoB_value; mq[i].jmp = CDBRoB_jump;
                    mrdy[CDBRoB_index] = 1'b1; mval[CDBRoB_index] = CDBRoB_value;
                end
        if (com) void'(mq.pop_front());
        if (DPRoB_en && !full) begin
            e.idx = mtail; e.typ = (DPRoB_type == 2'b11) ? 2'b10 : DPRoB_type;
            e.rd = (DPRoB_type == 2'b00) ? DPRoB_rd : NON_REG;
            e.pred = DPRoB_pred_jump; e.alt = DPRoB_alt_pc;
            e.rdy = 1'b0; e.val = '0; e.jmp = 1'b0;
            mq.push_back(e);
            mrdy[mtail] = 1'b0;
            mtail = (mtail + 1) % 256;
        end
    endtask

    task automatic step();
        @(posedge Sys_clk);
        model_edge();
        @(negedge Sys_clk);
    endtask

    task automatic idle();
        DPRoB_en = 0; DPRoB_type = 0; DPRoB_rd = 0; DPRoB_pred_jump = 0; DPRoB_alt_pc = 0;
        DPRoB_Qj = NON_DEP; DPRoB_Qk = NON_DEP;
        CDBRoB_en = 0; CDBRoB_index = 0; CDBRoB_value = 0; CDBRoB_jump = 0;
        Sys_rdy = 1;
    endtask

    task automatic do_reset();
        idle(); Sys_rst = 1; step(); step(); Sys_rst = 0;
    endtask

    task automatic disp(input logic [1:0] t, input logic [5:0] rd, input logic pj, input logic [31:0] pc);
        DPRoB_en = 1; DPRoB_type = t; DPRoB_rd = rd; DPRoB_pred_jump = pj; DPRoB_alt_pc = pc;
    endtask

    task automatic cdb(input logic [7:0] idx, input logic [31:0] v, input logic j);
        CDBRoB_en = 1; CDBRoB_index = idx; CDBRoB_value = v; CDBRoB_jump = j;
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        do_reset(); #1;
        n_tests++; if (RoBRF_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b exp 0", RoBRF_en); end
        n_tests++; if (RoBRF_pre_judge !== 1'b1 || RoBIF_flush !== 1'b0) begin n_fail++; $display("FAIL reset_pj got pj=%b fl=%b exp 1/0", RoBRF_pre_judge, RoBIF_flush); end
        n_tests++; if (RoBDP_full !== 1'b0 || RoBDP_index !== 8'd0) begin n_fail++; $display("FAIL reset_full got full=%b idx=%0d exp 0/0", RoBDP_full, RoBDP_index); end
    endtask

    task automatic test_commit_order();
        for (int i = 0; i < 3; i++) begin
            disp(2'b00, 6'(i + 1), 0, 0); #1;
            n_tests++; if (RoBDP_index !== 8'(i)) begin n_fail++; $display("FAIL alloc_index got %0d exp %0d", RoBDP_index, i); end
            step();
        end
        idle(); cdb(8'd1, 32'h11, 0); #1;
        n_tests++; if (RoBRF_en !== 1'b0) begin n_fail++; $display("FAIL early_commit got %b exp 0", RoBRF_en); end
        step(); cdb(8'd0, 32'h10, 0); #1;
        n_tests++; if (RoBRF_en !== 1'b0) begin n_fail++; $display("FAIL no_bypass got %b exp 0", RoBRF_en); end
        step(); idle(); #1;
        n_tests++; if (RoBRF_en !== 1'b1 || RoBRF_RoB_index !== 8'd0 || RoBRF_rd !== 6'd1 || RoBRF_value !== 32'h10) begin
            n_fail++; $display("FAIL commit0 got en=%b i=%0d rd=%0d v=%h exp 1/0/1/10", RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value); end
        step(); #1;
        n_tests++; if (RoBRF_en !== 1'b1 || RoBRF_RoB_index !== 8'd1 || RoBRF_rd !== 6'd2 || RoBRF_value !== 32'h11) begin
            n_fail++; $display("FAIL commit1 got en=%b i=%0d rd=%0d v=%h exp 1/1/2/11", RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value); end
        step(); #1;
        n_tests++; if (RoBRF_en !== 1'b0) begin n_fail++; $display("FAIL idx2_wait got %b exp 0", RoBRF_en); end
        cdb(8'd2, 32'h22, 0); step(); idle(); step();
    endtask

    task automatic test_mispredict_flush();
        disp(2'b01, NON_REG, 0, 32'h100); #1;
        n_tests++; if (RoBDP_index !== 8'd3) begin n_fail++; $display("FAIL br_index got %0d exp 3", RoBDP_index); end
        step(); idle(); cdb(8'd3, 32'h0, 1); step(); idle();
        disp(2'b00, 6'd9, 0, 0); #1;  // dispatch coincides with flush
        n_tests++; if (RoBRF_en !== 1'b1 || RoBRF_pre_judge !== 1'b0 || RoBIF_flush !== 1'b1 || RoBIF_pc !== 32'h100) begin
            n_fail++; $display("FAIL mispredict got en=%b pj=%b fl=%b pc=%h exp 1/0/1/100", RoBRF_en, RoBRF_pre_judge, RoBIF_flush, RoBIF_pc); end
        step(); idle(); #1;
        n_tests++; if (RoBDP_index !== 8'd0 || RoBDP_full !== 1'b0 || RoBRF_en !== 1'b0) begin
            n_fail++; $display("FAIL post_flush got idx=%0d full=%b en=%b exp 0/0/0", RoBDP_index, RoBDP_full, RoBRF_en); end
        disp(2'b00, 6'd7, 0, 0); step(); idle(); cdb(8'd0, 32'h77, 0); step(); idle(); #1;
        n_tests++; if (RoBRF_en !== 1'b1 || RoBRF_RoB_index !== 8'd0 || RoBRF_rd !== 6'd7) begin
            n_fail++; $display("FAIL flush_head got en=%b i=%0d rd=%0d exp 1/0/7", RoBRF_en, RoBRF_RoB_index, RoBRF_rd); end
        step();
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            disp(2'b10, NON_REG, 0, 0); #1;
            if (i == 255) begin
                n_tests++; if (RoBDP_full !== 1'b0 || RoBDP_index !== 8'd255) begin
                    n_fail++; $display("FAIL almost_full got full=%b idx=%0d exp 0/255", RoBDP_full, RoBDP_index); end
            end
            step();
        end
        idle(); #1;
        n_tests++; if (RoBDP_full !== 1'b1 || RoBDP_index !== 8'd0) begin n_fail++; $display("FAIL full got full=%b idx=%0d exp 1/0", RoBDP_full, RoBDP_index); end
        cdb(8'd0, 32'h5, 0); step(); idle();
        disp(2'b00, 6'd5, 0, 0); #1;  // blocked: full is still set on this edge
        n_tests++; if (RoBRF_en !== 1'b1 || RoBRF_rd !== NON_REG || RoBRF_pre_judge !== 1'b1 || RoBDP_full !== 1'b1) begin
            n_fail++; $display("FAIL store_commit got en=%b rd=%h pj=%b full=%b exp 1/20/1/1", RoBRF_en, RoBRF_rd, RoBRF_pre_judge, RoBDP_full); end
        step(); #1;
        n_tests++; if (RoBDP_full !== 1'b0 || RoBDP_index !== 8'd0) begin n_fail++; $display("FAIL full_drop got full=%b idx=%0d exp 0/0", RoBDP_full, RoBDP_index); end
        step(); idle(); #1;
        n_tests++; if (RoBDP_full !== 1'b1 || RoBDP_index !== 8'd1) begin n_fail++; $display("FAIL wrap_alloc got full=%b idx=%0d exp 1/1", RoBDP_full, RoBDP_index); end
    endtask

    task automatic test_lookup();
        do_reset();
        for (int i = 0; i < 6; i++) begin disp(2'b00, 6'(i), 0, 0); step(); end
        idle(); cdb(8'd5, 32'h55, 0); DPRoB_Qj = 9'd5; DPRoB_Qk = NON_DEP; #1;
        n_tests++; if (RoBDP_Vj_rdy !== 1'b1 || RoBDP_Vj !== 32'h55) begin n_fail++; $display("FAIL fwd_vj got rdy=%b v=%h exp 1/55", RoBDP_Vj_rdy, RoBDP_Vj); end
        n_tests++; if (RoBDP_Vk_rdy !== 1'b0 || RoBDP_Vk !== 32'h0) begin n_fail++; $display("FAIL nondep_vk got rdy=%b v=%h exp 0/0", RoBDP_Vk_rdy, RoBDP_Vk); end
        step(); idle(); DPRoB_Qj = 9'd5; DPRoB_Qk = 9'd4; #1;
        n_tests++; if (RoBDP_Vj_rdy !== 1'b1 || RoBDP_Vj !== 32'h55) begin n_fail++; $display("FAIL stored_vj got rdy=%b v=%h exp 1/55", RoBDP_Vj_rdy, RoBDP_Vj); end
        n_tests++; if (RoBDP_Vk_rdy !== 1'b0 || RoBDP_Vk !== 32'h0) begin n_fail++; $display("FAIL pending_vk got rdy=%b v=%h exp 0/0", RoBDP_Vk_rdy, RoBDP_Vk); end
    endtask

    task automatic test_sys_rdy();
        idle(); cdb(8'd0, 32'hA0, 0); step(); idle();
        Sys_rdy = 0; disp(2'b00, 6'd3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (RoBRF_en !== 1'b0 || RoBRF_pre_judge !== 1'b1 || RoBIF_flush !== 1'b0 || RoBDP_index !== 8'd6) begin
                n_fail++; $display("FAIL frozen got en=%b pj=%b fl=%b idx=%0d exp 0/1/0/6", RoBRF_en, RoBRF_pre_judge, RoBIF_flush, RoBDP_index); end
            step();
        end
        idle(); #1;
        n_tests++; if (RoBRF_en !== 1'b1 || RoBRF_RoB_index !== 8'd0 || RoBRF_value !== 32'hA0) begin
            n_fail++; $display("FAIL thaw got en=%b i=%0d v=%h exp 1/0/a0", RoBRF_en, RoBRF_RoB_index, RoBRF_value); end
        step();
    endtask

    // ---------------- randomized run against the queue model ----------------
    task automatic test_random();
        logic [32:0] ej, ek;
        bit een, emis;
        ent_t e;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            Sys_rst = ($urandom_range(0, 299) == 0);
            Sys_rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1) begin
                DPRoB_type = 2'($urandom_range(0, 3));
                disp(DPRoB_type, (DPRoB_type == 2'b00) ? 6'($urandom_range(0, 31)) : NON_REG,
                     1'($urandom_range(0, 1)), $urandom);
            end
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                e = mq[$urandom_range(0, mq.size() - 1)];
                cdb(8'(e.idx), $urandom, ($urandom_range(0, 7) == 0) ? ~e.pred : e.pred);
            end else if ($urandom_range(0, 3) == 0)
                cdb(8'($urandom_range(0, 255)), $urandom, 1'($urandom_range(0, 1)));
            DPRoB_Qj = ($urandom_range(0, 3) == 0) ? NON_DEP : 9'($urandom_range(0, 255));
            DPRoB_Qk = ($urandom_range(0, 3) == 0) ? NON_DEP : 9'($urandom_range(0, 255));
            #1;
            een = m_commit(); emis = m_mis();
            ej = m_look(DPRoB_Qj); ek = m_look(DPRoB_Qk);
            n_tests++; if (RoBRF_en !== een || RoBRF_pre_judge !== !emis || RoBIF_flush !== emis) begin
                n_fail++; $display("FAIL rnd_commit c=%0d got en=%b pj=%b fl=%b exp %b/%b/%b", c, RoBRF_en, RoBRF_pre_judge, RoBIF_flush, een, !emis, emis); end
            n_tests++; if (RoBDP_full !== (mq.size() == 256) || RoBDP_index !== 8'(mtail)) begin
                n_fail++; $display("FAIL rnd_alloc c=%0d got full=%b idx=%0d exp %b/%0d", c, RoBDP_full, RoBDP_index, mq.size() == 256, mtail); end
            n_tests++; if ({RoBDP_Vj_rdy, RoBDP_Vj} !== ej || {RoBDP_Vk_rdy, RoBDP_Vk} !== ek) begin
                n_fail++; $display("FAIL rnd_lookup c=%0d got j=%h k=%h exp j=%h k=%h", c, {RoBDP_Vj_rdy, RoBDP_Vj}, {RoBDP_Vk_rdy, RoBDP_Vk}, ej, ek); end
            if (een) begin
                n_tests++; if (RoBRF_RoB_index !== 8'(mq[0].idx) || RoBRF_rd !== mq[0].rd || RoBRF_value !== mq[0].val) begin
                    n_fail++; $display("FAIL rnd_head c=%0d got i=%0d rd=%h v=%h exp %0d/%h/%h", c, RoBRF_RoB_index, RoBRF_rd, RoBRF_value, mq[0].idx, mq[0].rd, mq[0].val); end
            end
            if (emis) begin
                n_tests++; if (RoBIF_pc !== mq[0].alt) begin n_fail++; $display("FAIL rnd_pc c=%0d got %h exp %h", c, RoBIF_pc, mq[0].alt); end
            end
            step();
        end
        Sys_rst = 0; idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_commit_order();
        test_mispredict_flush();
        test_full_wrap();
        test_lookup();
        test_sys_rdy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
